// File: rtl/ldst_unit.sv
// ldst_unit: single-outstanding load/store sequencer between decode and data memory,
// with ack timeout and a one-cycle register write-back pulse for loads.
module ldst_unit #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_is_load,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       mem_en,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    input  logic       mem_ack,
    output logic [7:0] dat_out,
    output logic       MemtoReg,
    output logic       busy,
    output logic       err_timeout
);
    typedef enum logic [1:0] {IDLE, ACCESS, WB} state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] dat_q, dat_d;
    logic       is_load_q, is_load_d;
    logic       err_q, err_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = 8'd0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        dat_d     = dat_q;
        is_load_d = is_load_q;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    is_load_d = req_is_load;
                    addr_d    = req_addr;
                    wdata_d   = req_wdata;
                    cnt_d     = 8'd1;
                    state_d   = ACCESS;
                end
            end
            ACCESS: begin
                // an ack on the final counted cycle still completes normally
                if (mem_ack) begin
                    if (is_load_q) begin
                        dat_d   = mem_rdata;
                        state_d = WB;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (cnt_q == TIMEOUT_CNT) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            addr_q    <= 8'd0;
            wdata_q   <= 8'd0;
            dat_q     <= 8'd0;
            is_load_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            dat_q     <= dat_d;
            is_load_q <= is_load_d;
            err_q     <= err_d;
        end
    end

    assign req_ready   = state_q == IDLE;
    assign busy        = state_q != IDLE;
    assign mem_en      = state_q == ACCESS;
    assign mem_we      = (state_q == ACCESS) && !is_load_q;
    assign MemtoReg    = state_q == WB;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign dat_out     = dat_q;
    assign err_timeout = err_q;
endmodule

// File: tb/tb_ldst_unit.sv
// tb_ldst_unit: transaction-level reference checks for ldst_unit with directed and random accesses.
module tb_ldst_unit;
    localparam int TIMEOUT = 15;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid, req_ready, req_is_load;
    logic [7:0] req_addr, req_wdata;
    logic       mem_en, mem_we;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       mem_ack;
    logic [7:0] dat_out;
    logic       MemtoReg, busy, err_timeout;

    int checks = 0;
    int errors = 0;

    // expected architectural state seen while idle
    logic [7:0] exp_dat, exp_addr, exp_wd;
    logic       exp_err;

    ldst_unit #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_load(req_is_load),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .dat_out(dat_out), .MemtoReg(MemtoReg), .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // outputs every idle cycle must show; the caller has already driven this cycle's inputs
    task automatic idle_checks(input string tag);
        @(negedge clk);
        chk({tag, ".req_ready"}, 8'(req_ready), 8'd1);
        chk({tag, ".busy"}, 8'(busy), 8'd0);
        chk({tag, ".mem_en"}, 8'(mem_en), 8'd0);
        chk({tag, ".mem_we"}, 8'(mem_we), 8'd0);
        chk({tag, ".MemtoReg"}, 8'(MemtoReg), 8'd0);
        chk({tag, ".err_timeout"}, 8'(err_timeout), 8'(exp_err));
        chk({tag, ".dat_out"}, dat_out, exp_dat);
        chk({tag, ".mem_addr"}, mem_addr, exp_addr);
        chk({tag, ".mem_wdata"}, mem_wdata, exp_wd);
    endtask

    task automatic idle_cycle(input string tag, input bit ack);
        req_valid = 1'b0;
        mem_ack   = ack;
        mem_rdata = 8'($urandom);
        idle_checks(tag);
        tick();
        mem_ack = 1'b0;
        exp_err = 1'b0;
    endtask

    // ack_at: ACCESS cycle (1-based) carrying mem_ack; 0 or > TIMEOUT means never acked
    task automatic txn(input string tag, input bit ld, input logic [7:0] a, input logic [7:0] wd,
                       input int ack_at, input logic [7:0] rd, input bit hold_valid);
        bit acked;
        acked       = ack_at >= 1 && ack_at <= TIMEOUT;
        req_valid   = 1'b1;
        req_is_load = ld;
        req_addr    = a;
        req_wdata   = wd;
        mem_ack     = 1'b0;
        idle_checks({tag, ".hs"});
        tick();
        exp_err  = 1'b0;
        exp_addr = a;
        exp_wd   = wd;
        for (int k = 1; k <= TIMEOUT; k++) begin
            req_valid   = hold_valid;
            req_addr    = 8'($urandom);
            req_wdata   = 8'($urandom);
            req_is_load = 1'($urandom);
            mem_ack     = (k == ack_at);
            mem_rdata   = (k == ack_at) ? rd : 8'($urandom);
            @(negedge clk);
            chk({tag, ".acc.mem_en"}, 8'(mem_en), 8'd1);
            chk({tag, ".acc.mem_we"}, 8'(mem_we), 8'(!ld));
            chk({tag, ".acc.mem_addr"}, mem_addr, a);
            chk({tag, ".acc.mem_wdata"}, mem_wdata, wd);
            chk({tag, ".acc.busy"}, 8'(busy), 8'd1);
            chk({tag, ".acc.req_ready"}, 8'(req_ready), 8'd0);
            chk({tag, ".acc.MemtoReg"}, 8'(MemtoReg), 8'd0);
            chk({tag, ".acc.err"}, 8'(err_timeout), 8'd0);
            tick();
            if (k == ack_at) break;
        end
        if (acked && ld) begin
            exp_dat   = rd;
            mem_ack   = 1'b1;
            mem_rdata = ~rd;
            @(negedge clk);
            chk({tag, ".wb.MemtoReg"}, 8'(MemtoReg), 8'd1);
            chk({tag, ".wb.dat_out"}, dat_out, rd);
            chk({tag, ".wb.busy"}, 8'(busy), 8'd1);
            chk({tag, ".wb.mem_en"}, 8'(mem_en), 8'd0);
            chk({tag, ".wb.req_ready"}, 8'(req_ready), 8'd0);
            chk({tag, ".wb.err"}, 8'(err_timeout), 8'd0);
            tick();
        end
        mem_ack = 1'b0;
        exp_err = !acked;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_is_load = 1'b0; req_addr = 8'd0;
        req_wdata = 8'd0; mem_rdata = 8'd0; mem_ack = 1'b0;
        exp_dat = 8'd0; exp_addr = 8'd0; exp_wd = 8'd0; exp_err = 1'b0;
        tick();
        tick();
        idle_checks("reset");
        tick();
        rst_n = 1'b1;
        idle_cycle("post_reset", 1'b1);

        txn("load_a5", 1'b1, 8'h10, 8'h00, 3, 8'hA5, 1'b0);
        txn("store_3c", 1'b0, 8'h22, 8'h3C, 1, 8'h00, 1'b0);
        idle_cycle("after_store", 1'b0);
        txn("load_to", 1'b1, 8'h44, 8'h00, 0, 8'h00, 1'b0);
        idle_cycle("after_timeout", 1'b0);
        txn("store_to", 1'b0, 8'h55, 8'h99, 0, 8'h00, 1'b0);
        txn("load_edge", 1'b1, 8'h66, 8'h00, TIMEOUT, 8'h7E, 1'b0);
        idle_cycle("idle_ack", 1'b1);

        txn("b2b_1", 1'b1, 8'h30, 8'h00, 2, 8'h11, 1'b1);
        txn("b2b_2", 1'b1, 8'h31, 8'h00, 1, 8'h22, 1'b1);
        idle_cycle("after_b2b", 1'b0);

        // reset in the middle of an ACCESS, then a late ack
        req_valid = 1'b1; req_is_load = 1'b1; req_addr = 8'h77; req_wdata = 8'h88;
        idle_checks("rst_hs");
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        chk("rst.acc.mem_en", 8'(mem_en), 8'd1);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_dat = 8'd0; exp_addr = 8'd0; exp_wd = 8'd0; exp_err = 1'b0;
        mem_rdata = 8'hFF;
        idle_cycle("rst_late_ack", 1'b1);
        idle_cycle("rst_after", 1'b0);

        for (int i = 0; i < 30; i++) begin
            txn($sformatf("rnd%0d", i), 1'($urandom), 8'($urandom), 8'($urandom),
                int'($urandom_range(0, TIMEOUT + 2)), 8'($urandom), 1'($urandom));
        end
        idle_cycle("final", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ldst_unit.md
LDST_UNIT -- requirements
Module: ldst_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, max cycles waited for mem_ack before abort (legal range 1..255).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  load/store request from decode.
REQ-005 SHALL have port req_ready  output  1  unit accepts a request this cycle.
REQ-006 SHALL have port req_is_load  input  1  1 = load, 0 = store.
REQ-007 SHALL have port req_addr  input  8  data memory address.
REQ-008 SHALL have port req_wdata  input  8  store data.
REQ-009 SHALL have port mem_en  output  1  memory access strobe.
REQ-010 SHALL have port mem_we  output  1  memory write enable.
REQ-011 SHALL have port mem_addr  output  8  memory address.
REQ-012 SHALL have port mem_wdata  output  8  memory write data.
REQ-013 SHALL have port mem_rdata  input  8  memory read data, valid with mem_ack.
REQ-014 SHALL have port mem_ack  input  1  memory completion, one-cycle pulse.
REQ-015 SHALL have port dat_out  output  8  load result for the register file data input.
REQ-016 SHALL have port MemtoReg  output  1  one-cycle pulse committing dat_out to register 2.
REQ-017 SHALL have port busy  output  1  access in flight; stalls fetch.
REQ-018 SHALL have port err_timeout  output  1  one-cycle pulse on access abort.

Function
REQ-019 SHALL implement FSM states IDLE, ACCESS, WB; all outputs registered or decoded from state only.
REQ-020 SHALL drive req_ready = 1 only in IDLE; handshake occurs when req_valid && req_ready.
REQ-021 SHALL, on handshake in IDLE, latch req_is_load/req_addr/req_wdata and enter ACCESS next cycle.
REQ-022 SHALL, in ACCESS, hold mem_en = 1, mem_we = !latched is_load, mem_addr/mem_wdata = latched values, stable until exit.
REQ-023 SHALL drive mem_en = mem_we = 0 in IDLE and WB; mem_addr/mem_wdata hold last values.
REQ-024 SHALL, in ACCESS, count cycles from 1 at entry; mem_ack in any ACCESS cycle ends the access.
REQ-025 SHALL, on mem_ack for a load, capture mem_rdata into dat_out and enter WB.
REQ-026 SHALL, in WB, assert MemtoReg for exactly one cycle, then return to IDLE; dat_out holds until next load capture.
REQ-027 SHALL, on mem_ack for a store, return to IDLE directly; no MemtoReg pulse.
REQ-028 SHALL, when count reaches TIMEOUT with no mem_ack, pulse err_timeout next cycle, return to IDLE, no MemtoReg, dat_out unchanged.
REQ-029 SHALL give mem_ack priority when it coincides with the TIMEOUT cycle (normal completion, no error).
REQ-030 SHALL ignore mem_ack in IDLE and WB.
REQ-031 SHALL drive busy = 1 in ACCESS and WB, 0 in IDLE.
REQ-032 SHALL give load latency: handshake cycle N, mem_en from N+1, ack at cycle M, MemtoReg high in cycle M+1, req_ready high at M+2.
REQ-033 SHALL ignore req_valid while not in IDLE; no request is queued.

Reset
REQ-034 SHALL, on posedge clk with rst_n = 0, force IDLE, counter 0, and set all outputs to 0 except req_ready = 1.
REQ-035 SHALL abort an in-flight access on reset with no MemtoReg and no err_timeout pulse; a late mem_ack after reset is ignored.

Verification
REQ-036 Load at addr 0x10, mem_ack after 3 cycles with rdata 0xA5 -> dat_out = 0xA5, one MemtoReg pulse at ack+1, req_ready at ack+2.
REQ-037 Store 0x3C to 0x22, immediate ack -> mem_we = 1 for one cycle, mem_wdata = 0x3C, no MemtoReg, IDLE next cycle.
REQ-038 Load with no ack, TIMEOUT = 15 -> err_timeout pulse after 15 ACCESS cycles, no MemtoReg, dat_out keeps prior 0xA5.
REQ-039 mem_ack exactly on cycle 15 with rdata 0x7E -> normal WB with 0x7E, err_timeout stays 0.
REQ-040 rst_n low during ACCESS, then mem_ack arrives -> IDLE, req_ready = 1, outputs 0, no MemtoReg or err_timeout.
REQ-041 req_valid held high across back-to-back loads -> second accepted only in the IDLE cycle after WB; busy drops for exactly that cycle.
